r_peak_detector: RTL and testbench

//  Parametrised R-peak detector for the ECG filter chain; successor to the

---
 rtl/r_peak_detector.sv | 135 +++++++++++++
 tb/tb_r_peak_detector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/r_peak_detector.sv
// R-peak detector: signed first difference of the filtered ECG stream drives a
// rise/fall slope FSM with timeout, followed by a refractory hold-off window.
module r_peak_detector #(
  parameter int DATA_W   = 8,
  parameter int TH_POS   = 9,
  parameter int TH_NEG   = -6,
  parameter int MAX_RISE = 32,
  parameter int REFRACT  = 50,
  parameter int RR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W:0]   diff,
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_amp,
  output logic [RR_W-1:0]   rr_interval,
  output logic              busy
);

  localparam int RISE_W = (MAX_RISE > 1) ? $clog2(MAX_RISE) : 1;
  localparam int REF_W  = (REFRACT > 1) ? $clog2(REFRACT) : 1;

  localparam logic signed [DATA_W:0] TH_POS_D  = (DATA_W+1)'(TH_POS);
  localparam logic signed [DATA_W:0] TH_NEG_D  = (DATA_W+1)'(TH_NEG);
  localparam logic [RISE_W-1:0]      RISE_LAST = RISE_W'(MAX_RISE - 1);
  localparam logic [REF_W-1:0]       REF_LAST  = REF_W'(REFRACT - 1);
  localparam logic [RISE_W-1:0]      RISE_ONE  = RISE_W'(1);
  localparam logic [REF_W-1:0]       REF_ONE   = REF_W'(1);
  localparam logic [RR_W-1:0]        RR_ONE    = RR_W'(1);
  localparam logic [RR_W-1:0]        RR_MAX    = {RR_W{1'b1}};

  // The peak-output step is folded into the RISE->REFRACT transition.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISE    = 2'd1,
    REFRACT_ST = 2'd2
  } state_t;

  state_t                   state;
  logic [DATA_W-1:0]        d_prev;
  logic                     prev_ok;
  logic [DATA_W-1:0]        amp_max;
  logic [RISE_W-1:0]        rise_cnt;
  logic [REF_W-1:0]         ref_cnt;
  logic [RR_W-1:0]          rr_cnt;

  logic signed [DATA_W:0]   diff_c;
  logic                     is_rise;
  logic                     is_fall;
  logic [DATA_W-1:0]        amp_next;
  logic [RR_W-1:0]          rr_inc;

  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Slope, threshold compares and saturating RR increment for the current sample.
  always_comb begin
    diff_c   = $signed({1'b0, d_in}) - $signed({1'b0, d_prev});
    is_rise  = (diff_c >= TH_POS_D);
    is_fall  = (diff_c <= TH_NEG_D);
    amp_next = max_u(amp_max, d_in);
    rr_inc   = (rr_cnt == RR_MAX) ? rr_cnt : rr_cnt + RR_ONE;
  end

  // Sample-strobed detector FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      d_prev      <= '0;
      prev_ok     <= 1'b0;
      amp_max     <= '0;
      rise_cnt    <= '0;
      ref_cnt     <= '0;
      rr_cnt      <= '0;
      diff        <= '0;
      peak_valid  <= 1'b0;
      peak_amp    <= '0;
      rr_interval <= '0;
      busy        <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (in_valid) begin
        d_prev  <= d_in;
        prev_ok <= 1'b1;
        rr_cnt  <= rr_inc;
        diff    <= prev_ok ? diff_c : '0;
        if (prev_ok) begin
          case (state)
            IDLE: begin
              if (is_rise) begin
                state    <= RISE;
                amp_max  <= d_in;
                rise_cnt <= '0;
                busy     <= 1'b1;
              end
            end
            RISE: begin
              amp_max <= amp_next;
              if (is_fall) begin
                peak_valid  <= 1'b1;
                peak_amp    <= amp_next;
                rr_interval <= rr_cnt;
                rr_cnt      <= RR_ONE;
                ref_cnt     <= '0;
                state       <= REFRACT_ST;
              end else if (rise_cnt == RISE_LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                rise_cnt <= rise_cnt + RISE_ONE;
              end
            end
            REFRACT_ST: begin
              if (ref_cnt == REF_LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                ref_cnt <= ref_cnt + REF_ONE;
              end
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_r_peak_detector.sv
// Randomised and directed bench for r_peak_detector against a sample-level
// behavioural model of the detection rules.
module tb_r_peak_detector;

  localparam int MAX_RISE = 32;
  localparam int REFRACT  = 50;
  localparam int RR_SAT   = 4095;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] d_in = 8'd0;
  logic [8:0] diff;
  logic       peak_valid;
  logic [7:0] peak_amp;
  logic [11:0] rr_interval;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int gap_pct = 0;

  // model state: mode 0 idle, 1 rising, 2 refractory
  int m_prev, m_ok, m_mode, m_amp, m_since, m_rr;
  int e_diff, e_pv, e_amp, e_rr, e_busy;

  r_peak_detector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in),
    .diff(diff), .peak_valid(peak_valid), .peak_amp(peak_amp),
    .rr_interval(rr_interval), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_ok = 0; m_mode = 0; m_amp = 0; m_since = 0; m_rr = 0;
    e_diff = 0; e_pv = 0; e_amp = 0; e_rr = 0; e_busy = 0;
  endtask

  task automatic model_step(input bit v, input int d);
    int dd;
    int old_rr;
    e_pv = 0;
    if (v) begin
      old_rr = m_rr;
      if (m_rr < RR_SAT) m_rr++;
      if (m_ok == 0) begin
        e_diff = 0;
      end else begin
        dd = d - m_prev;
        e_diff = dd;
        if (m_mode == 0) begin
          if (dd >= 9) begin
            m_mode = 1; m_amp = d; m_since = 0;
          end
        end else if (m_mode == 1) begin
          if (d > m_amp) m_amp = d;
          if (dd <= -6) begin
            e_pv = 1; e_amp = m_amp; e_rr = old_rr;
            m_rr = 1; m_mode = 2; m_since = 0;
          end else begin
            m_since++;
            if (m_since == MAX_RISE) m_mode = 0;
          end
        end else begin
          m_since++;
          if (m_since == REFRACT) m_mode = 0;
        end
      end
      m_prev = d;
      m_ok = 1;
      e_busy = (m_mode != 0) ? 1 : 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".diff"}, $signed(diff), e_diff);
    check_val({tag, ".peak_valid"}, int'(peak_valid), e_pv);
    check_val({tag, ".peak_amp"}, int'(peak_amp), e_amp);
    check_val({tag, ".rr_interval"}, int'(rr_interval), e_rr);
    check_val({tag, ".busy"}, int'(busy), e_busy);
  endtask

  task automatic step(input bit v, input int d);
    @(negedge clk);
    in_valid = v;
    d_in = d[7:0];
    @(posedge clk);
    #1;
    model_step(v, d);
    check_outputs(v ? "smp" : "gap");
    if (peak_valid) pulses++;
  endtask

  task automatic sample(input int d);
    while ($urandom_range(99) < gap_pct) step(1'b0, int'($urandom_range(255)));
    step(1'b1, d);
  endtask

  task automatic flats(input int n, input int d);
    for (int i = 0; i < n; i++) sample(d);
  endtask

  task automatic peak_shape();
    sample(120); sample(140); sample(150); sample(130); sample(100);
  endtask

  initial begin
    int cur;
    int r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // basic peak
    pulses = 0;
    sample(100); sample(100);
    peak_shape();
    check_val("peak_cnt", pulses, 1);
    check_val("peak_amp150", int'(peak_amp), 150);
    flats(60, 100);

    // RR interval between two identical peaks
    pulses = 0;
    peak_shape();
    flats(195, 100);
    peak_shape();
    check_val("rr_cnt", pulses, 2);
    check_val("rr_200", int'(rr_interval), 200);

    // refractory suppression, then acceptance
    pulses = 0;
    flats(10, 100);
    peak_shape();
    check_val("refr_block", pulses, 0);
    flats(60, 100);
    peak_shape();
    check_val("refr_pass", pulses, 1);
    flats(60, 100);

    // rise timeout
    pulses = 0;
    sample(120);
    flats(40, 120);
    check_val("tmo_cnt", pulses, 0);
    check_val("tmo_busy", int'(busy), 0);
    flats(5, 100);

    // exact thresholds and full-scale step
    pulses = 0;
    sample(100); sample(109); sample(103);
    check_val("thr_cnt", pulses, 1);
    flats(60, 103);
    sample(0); sample(255);
    check_val("step_diff", $signed(diff), 255);
    sample(0);
    flats(60, 0);

    // same basic peak with gaps in the sample strobe
    gap_pct = 40;
    pulses = 0;
    flats(3, 100);
    peak_shape();
    check_val("gap_cnt", pulses, 1);
    check_val("gap_amp", int'(peak_amp), 150);
    flats(60, 100);
    gap_pct = 0;

    // async reset in the middle of a rise
    flats(2, 100);
    sample(130); sample(140);
    check_val("pre_rst_busy", int'(busy), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    sample(100); sample(100);
    peak_shape();
    check_val("post_rst_cnt", pulses, 1);

    // randomised random-walk traffic with strobe gaps
    gap_pct = 25;
    cur = 100;
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(99));
      if (r < 60)      cur = cur + int'($urandom_range(8)) - 4;
      else if (r < 78) cur = cur + int'($urandom_range(30));
      else if (r < 95) cur = cur - int'($urandom_range(30));
      else             cur = int'($urandom_range(255));
      if (cur < 0) cur = 0;
      if (cur > 255) cur = 255;
      sample(cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
